// File: rtl/retire_trace_buffer_if.sv
// Retirement-trace bus bundle.
// Carries the retire-event side (ret_*, halt) from the CPU writeback stage and
// the record side (rec_*, level, drop_cnt, done) toward the trace logger.
//   slave  : the trace buffer itself
//   master : the environment (retire source + logger)
interface retire_trace_buffer_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             ret_valid;
  logic [1:0]       ret_kind;
  logic [15:0]      ret_pc;
  logic [15:0]      ret_addr;
  logic [15:0]      ret_data;
  logic             halt;
  logic             rec_ready;
  logic             rec_valid;
  logic [1:0]       rec_kind;
  logic [15:0]      rec_pc;
  logic [15:0]      rec_addr;
  logic [15:0]      rec_data;
  logic [15:0]      rec_seq;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] drop_cnt;
  logic             done;

  modport slave (
    input  ret_valid, ret_kind, ret_pc, ret_addr, ret_data, halt, rec_ready,
    output rec_valid, rec_kind, rec_pc, rec_addr, rec_data, rec_seq,
           level, drop_cnt, done
  );

  modport master (
    output ret_valid, ret_kind, ret_pc, ret_addr, ret_data, halt, rec_ready,
    input  rec_valid, rec_kind, rec_pc, rec_addr, rec_data, rec_seq,
           level, drop_cnt, done
  );
endinterface

// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer.
// Packs each retired instruction (kind, pc, addr, data, sequence number) into a
// record and queues it in a first-word-fall-through FIFO drained by the trace
// logger over a valid/ready handshake. On halt, new events are refused, the
// FIFO drains, and done is raised and held until reset.
// Ports:
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : retire_trace_buffer_if.slave (ret_* / halt in, rec_* / level /
//            drop_cnt / done out)
//
// state | meaning
// RUN   | accepting retire events
// DRAIN | halt seen; events ignored, FIFO draining
// DONE  | halted and empty; done=1 until reset
module retire_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  retire_trace_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = 2 + 16 * 4;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             accepting;
  logic             done;

  logic [RW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_q;
  logic [15:0]      seq_q;
  logic [CNT_W-1:0] drop_q;

  logic             rec_valid, full, pop, push_req, do_push, drop;
  logic [RW-1:0]    head;

  assign rec_valid = (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign pop       = rec_valid && bus.rec_ready;
  assign push_req  = accepting && bus.ret_valid && (bus.ret_kind != 2'b11);
  // A full FIFO can still take a record when the head leaves in the same cycle.
  assign do_push   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= {bus.ret_kind, bus.ret_pc, bus.ret_addr, bus.ret_data, seq_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      // Dropped records still burn a sequence number so gaps are visible downstream.
      if (push_req) seq_q <= seq_q + 16'd1;
      if (drop && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (bus.halt) state_nxt = S_DRAIN;
      S_DRAIN: if (level_q == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    accepting = 1'b0;
    done      = 1'b0;
    case (state)
      S_RUN:   accepting = 1'b1;
      S_DONE:  done      = 1'b1;
      default: ;
    endcase
  end

  // Head record is forced to zero while empty so stale storage never shows.
  assign head          = rec_valid ? mem[rd_ptr] : '0;
  assign bus.rec_valid = rec_valid;
  assign bus.rec_kind  = head[65:64];
  assign bus.rec_pc    = head[63:48];
  assign bus.rec_addr  = head[47:32];
  assign bus.rec_data  = head[31:16];
  assign bus.rec_seq   = head[15:0];
  assign bus.level     = level_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.done      = done;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed testbench for retire_trace_buffer with a record scoreboard.
// Inputs change 1 time unit after posedge; checks and the reference queue
// update happen on the negedge before the edge that acts on those inputs.
module tb_retire_trace_buffer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] seq;
  } rec_t;

  logic clk;
  logic rst_n;

  retire_trace_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  retire_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  rec_t        exp_q[$];
  logic [15:0] m_seq;
  logic [7:0]  m_drop;
  int          m_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_seq   = '0;
    m_drop  = '0;
    m_state = 0;
  endtask

  // One clock: check outputs against the scoreboard, advance the reference, step.
  task automatic step();
    bit   pop, preq;
    int   sz;
    rec_t r;
    @(negedge clk);
    sz = exp_q.size();
    chk("rec_valid", 32'(bus.rec_valid), 32'(sz != 0));
    chk("level", 32'(bus.level), 32'(sz));
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    chk("done", 32'(bus.done), 32'(m_state == 2));
    pop = (sz != 0) && bus.rec_ready;
    if (pop) begin
      chk("head_kind", 32'(bus.rec_kind), 32'(exp_q[0].kind));
      chk("head_pc", 32'(bus.rec_pc), 32'(exp_q[0].pc));
      chk("head_addr", 32'(bus.rec_addr), 32'(exp_q[0].addr));
      chk("head_data", 32'(bus.rec_data), 32'(exp_q[0].data));
      chk("head_seq", 32'(bus.rec_seq), 32'(exp_q[0].seq));
      void'(exp_q.pop_front());
    end else if (sz == 0) begin
      chk("empty_rec_zero",
          {14'(bus.rec_kind), bus.rec_pc | bus.rec_addr | bus.rec_data | bus.rec_seq}, 32'd0);
    end
    preq = (m_state == 0) && bus.ret_valid && (bus.ret_kind != 2'b11);
    if (preq) begin
      if (sz < DEPTH || pop) begin
        r.kind = bus.ret_kind; r.pc = bus.ret_pc; r.addr = bus.ret_addr;
        r.data = bus.ret_data; r.seq = m_seq;
        exp_q.push_back(r);
      end else if (m_drop != 8'hFF) begin
        m_drop++;
      end
      m_seq++;
    end
    if (m_state == 0 && bus.halt) m_state = 1;
    else if (m_state == 1 && sz == 0) m_state = 2;
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [1:0] k, input logic [15:0] pc, input logic [15:0] a,
                    input logic [15:0] d);
    bus.ret_valid = 1'b1;
    bus.ret_kind  = k;
    bus.ret_pc    = pc;
    bus.ret_addr  = a;
    bus.ret_data  = d;
  endtask

  task automatic idle();
    bus.ret_valid = 1'b0;
    bus.halt      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_valid", 32'(bus.rec_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_kind  = 2'b00;
    bus.ret_pc    = '0;
    bus.ret_addr  = '0;
    bus.ret_data  = '0;
    bus.halt      = 1'b0;
    bus.rec_ready = 1'b0;
    do_reset();
    chk("rst_rec_data", 32'(bus.rec_data), 32'd0);

    // single register-write event
    bus.rec_ready = 1'b1;
    ev(2'b00, 16'h0004, 16'h0003, 16'hBEEF);
    step();
    idle();
    chk("t1_valid", 32'(bus.rec_valid), 32'd1);
    chk("t1_pc", 32'(bus.rec_pc), 32'h0004);
    chk("t1_addr", 32'(bus.rec_addr), 32'h0003);
    chk("t1_data", 32'(bus.rec_data), 32'hBEEF);
    chk("t1_seq", 32'(bus.rec_seq), 32'h0000);
    step();
    step();

    // overflow: 10 pushes into 8 entries
    do_reset();
    bus.rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ev(2'b01, 16'(16'h0100 + i * 4), 16'(16'h2000 + i), 16'(16'h1000 + i));
      step();
    end
    idle();
    chk("t2_level", 32'(bus.level), 32'd8);
    chk("t2_drop", 32'(bus.drop_cnt), 32'd2);
    chk("t2_head_seq", 32'(bus.rec_seq), 32'd0);

    // full FIFO with simultaneous push and pop
    bus.rec_ready = 1'b1;
    ev(2'b10, 16'h0300, 16'h0000, 16'h0400);
    step();
    idle();
    chk("t3_level", 32'(bus.level), 32'd8);
    chk("t3_drop", 32'(bus.drop_cnt), 32'd2);
    chk("t3_head_seq", 32'(bus.rec_seq), 32'd1);
    for (int i = 0; i < 9; i++) step();
    chk("t3_empty", 32'(bus.level), 32'd0);

    // reserved kind is ignored
    do_reset();
    ev(2'b11, 16'h0500, 16'h0001, 16'h0002);
    step();
    idle();
    chk("t4_level", 32'(bus.level), 32'd0);
    chk("t4_drop", 32'(bus.drop_cnt), 32'd0);
    ev(2'b00, 16'h0504, 16'h0007, 16'h00AA);
    step();
    idle();
    chk("t4_seq", 32'(bus.rec_seq), 32'd0);
    step();

    // halt with an event in the same cycle, then drain to done
    do_reset();
    bus.rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ev(2'b00, 16'(16'h0600 + i * 4), 16'(i), 16'(16'h3000 + i));
      step();
    end
    bus.rec_ready = 1'b1;
    ev(2'b10, 16'h060C, 16'h0000, 16'h0700);
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    ev(2'b00, 16'h0610, 16'h0009, 16'h0999);
    chk("t5_level_after_halt", 32'(bus.level), 32'd3);
    for (int i = 0; i < 3; i++) step();
    chk("t5_level_zero", 32'(bus.level), 32'd0);
    chk("t5_done_not_yet", 32'(bus.done), 32'd0);
    step();
    chk("t5_done", 32'(bus.done), 32'd1);
    bus.halt = 1'b1;
    step();
    step();
    idle();
    chk("t5_done_sticky", 32'(bus.done), 32'd1);
    chk("t5_ignored", 32'(bus.level), 32'd0);

    // reset mid-drain, then sequence wrap
    do_reset();
    bus.rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ev(2'b00, 16'(i), 16'(i), 16'(i));
      step();
    end
    idle();
    bus.halt      = 1'b1;
    bus.rec_ready = 1'b1;
    step();
    bus.halt = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("t6_valid", 32'(bus.rec_valid), 32'd0);
    chk("t6_level", 32'(bus.level), 32'd0);
    chk("t6_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      ev(2'b00, 16'(i), 16'(i >> 3), 16'(~i));
      step();
    end
    idle();
    step();
    ev(2'b01, 16'hABCD, 16'h1234, 16'h5678);
    step();
    idle();
    chk("t6_wrap_seq", 32'(bus.rec_seq), 32'd0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
